// File: rtl/divclk_monitor_if.sv
// divclk_monitor_if: bundle between a divided-clock tap and its monitor.
//  slow_in       divided-clock bit (asynchronous to clk)
//  tick_en       one-cycle enable per synchronised rising edge
//  period        clk cycles between the last two rising edges
//  period_valid  period holds a complete measurement
//  locked        two consecutive periods agree within tolerance
//  lost          no rising edge for the timeout window
// master = tap side (drives slow_in), slave = monitor side.
interface divclk_monitor_if #(
  parameter int PERIOD_W = 24
);
  logic                slow_in;
  logic                tick_en;
  logic [PERIOD_W-1:0] period;
  logic                period_valid;
  logic                locked;
  logic                lost;

  modport master (output slow_in, input tick_en, period, period_valid, locked, lost);
  modport slave  (input slow_in, output tick_en, period, period_valid, locked, lost);
endinterface

// File: rtl/divclk_monitor.sv
// divclk_monitor: receives one slow divided-clock tap, turns its rising edges
// into single-cycle clk enables, measures its period in clk cycles and
// reports lock / loss-of-clock status.
// Ports:
//  clk   system clock
//  clr   asynchronous active-high clear
//  mon   divclk_monitor_if.slave (slow_in in; tick_en, period,
//        period_valid, locked, lost out, all registered)
module divclk_monitor #(
  parameter int SYNC_STAGES = 2,
  parameter int PERIOD_W    = 24,
  parameter int TIMEOUT     = 2**22,
  parameter int TOL         = 4
)(
  input  logic            clk,
  input  logic            clr,
  divclk_monitor_if.slave mon
);

  typedef enum logic [2:0] {IDLE, MEASURE, LOCKWAIT, LOCKED, LOST} state_t;

  localparam logic [PERIOD_W-1:0] CNT_MAX = '1;
  localparam logic [PERIOD_W-1:0] TO_LAST = PERIOD_W'(TIMEOUT - 1);
  localparam logic [PERIOD_W:0]   TOL_W   = (PERIOD_W+1)'(TOL);

  // synchroniser + edge detect
  logic [SYNC_STAGES-1:0] sync_pipe;
  logic                   s_prev;
  logic                   rise;
  logic                   rise_q;   // edge flop; the FSM and counter act on this

  assign rise = sync_pipe[SYNC_STAGES-1] & ~s_prev;

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      sync_pipe <= '0;
      s_prev    <= 1'b0;
      rise_q    <= 1'b0;
    end else begin
      sync_pipe <= {sync_pipe[SYNC_STAGES-2:0], mon.slow_in};
      s_prev    <= sync_pipe[SYNC_STAGES-1];
      rise_q    <= rise;
    end
  end

  // measurement state
  state_t              state;
  logic [PERIOD_W-1:0] cnt;
  logic [PERIOD_W-1:0] period_q;
  logic                tick_q;
  logic                pvalid_q;
  logic                locked_q;
  logic                lost_q;

  // Candidate period: cycles since the previous edge, inclusive of this one.
  // Held at all-ones once the counter saturates rather than wrapping to 0.
  logic [PERIOD_W-1:0] p_cand;
  logic [PERIOD_W:0]   diff_raw;
  logic [PERIOD_W:0]   diff_mag;
  logic                in_tol;
  logic                timeout;

  assign p_cand   = (cnt == CNT_MAX) ? CNT_MAX : cnt + PERIOD_W'(1);
  // One extra bit keeps the signed difference exact for any pair of periods.
  assign diff_raw = {1'b0, p_cand} - {1'b0, period_q};
  assign diff_mag = diff_raw[PERIOD_W] ? (~diff_raw + (PERIOD_W+1)'(1)) : diff_raw;
  assign in_tol   = (diff_mag <= TOL_W);
  // A rise in the same cycle takes priority over the timeout.
  assign timeout  = (cnt == TO_LAST) && !rise_q;

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state    <= IDLE;
      cnt      <= '0;
      period_q <= '0;
      tick_q   <= 1'b0;
      pvalid_q <= 1'b0;
      locked_q <= 1'b0;
      lost_q   <= 1'b0;
    end else begin
      tick_q <= rise_q;

      if (rise_q)              cnt <= '0;
      else if (cnt != CNT_MAX) cnt <= cnt + PERIOD_W'(1);

      unique case (state)
        IDLE: begin
          if (rise_q) state <= MEASURE;
        end
        MEASURE: begin
          if (rise_q) begin
            state    <= LOCKWAIT;
            period_q <= p_cand;
            pvalid_q <= 1'b1;
          end else if (timeout) begin
            state    <= LOST;
            lost_q   <= 1'b1;
            locked_q <= 1'b0;
            pvalid_q <= 1'b0;
          end
        end
        LOCKWAIT: begin
          if (rise_q) begin
            period_q <= p_cand;
            if (in_tol) begin
              state    <= LOCKED;
              locked_q <= 1'b1;
            end
          end else if (timeout) begin
            state    <= LOST;
            lost_q   <= 1'b1;
            locked_q <= 1'b0;
            pvalid_q <= 1'b0;
          end
        end
        LOCKED: begin
          if (rise_q) begin
            period_q <= p_cand;
            if (!in_tol) begin
              state    <= LOCKWAIT;
              locked_q <= 1'b0;
            end
          end else if (timeout) begin
            state    <= LOST;
            lost_q   <= 1'b1;
            locked_q <= 1'b0;
            pvalid_q <= 1'b0;
          end
        end
        LOST: begin
          // The partial interval before this edge is dropped: the edge only
          // restarts measurement, exactly like the first edge out of IDLE.
          if (rise_q) begin
            state  <= MEASURE;
            lost_q <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign mon.tick_en      = tick_q;
  assign mon.period       = period_q;
  assign mon.period_valid = pvalid_q;
  assign mon.locked       = locked_q;
  assign mon.lost         = lost_q;

endmodule

// File: tb/tb_divclk_monitor.sv
module tb_divclk_monitor;
  localparam int PW = 24;

  logic clk = 1'b0;
  logic clr = 1'b1;
  int   errors = 0;
  int   checks = 0;
  int   tick_cnt = 0;
  int   cyc_no = 0;
  int   last_tick = 0;
  int   prev_tick = 0;

  divclk_monitor_if #(.PERIOD_W(PW)) mon_if();

  divclk_monitor #(
    .SYNC_STAGES(2), .PERIOD_W(PW), .TIMEOUT(64), .TOL(1)
  ) dut (
    .clk(clk), .clr(clr), .mon(mon_if)
  );

  always #5 clk = ~clk;

  // count tick pulses and remember when the last two happened
  always @(negedge clk) begin
    cyc_no <= cyc_no + 1;
    if (mon_if.tick_en) begin
      tick_cnt  <= tick_cnt + 1;
      prev_tick <= last_tick;
      last_tick <= cyc_no;
    end
  end

  // advance n clock edges, then settle 1 time unit past the edge
  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // one square-wave period of p cycles starting with the rising edge
  task automatic pulse_period(input int p);
    mon_if.slow_in = 1'b1;
    cyc(p / 2);
    mon_if.slow_in = 1'b0;
    cyc(p - p / 2);
  endtask

  task automatic check_status(input string name, input logic [PW-1:0] exp_period,
                              input logic exp_valid, input logic exp_locked, input logic exp_lost);
    checks++;
    if (mon_if.period !== exp_period || mon_if.period_valid !== exp_valid ||
        mon_if.locked !== exp_locked || mon_if.lost !== exp_lost) begin
      errors++;
      $display("FAIL %s: got period=%0d valid=%b locked=%b lost=%b, want period=%0d valid=%b locked=%b lost=%b",
               name, mon_if.period, mon_if.period_valid, mon_if.locked, mon_if.lost,
               exp_period, exp_valid, exp_locked, exp_lost);
    end
  endtask

  task automatic test_reset();
    mon_if.slow_in = 1'b0;
    clr = 1'b1;
    cyc(3);
    check_status("reset_outputs", 0, 0, 0, 0);
    checks++;
    if (mon_if.tick_en !== 1'b0) begin
      errors++; $display("FAIL reset_tick: got %b want 0", mon_if.tick_en);
    end
    clr = 1'b0;
    cyc(2);
  endtask

  task automatic test_square();
    int t0;
    t0 = tick_cnt;
    // first period by hand to pin down the edge-to-tick latency
    mon_if.slow_in = 1'b1;
    cyc(3);
    checks++;
    if (mon_if.tick_en !== 1'b0) begin
      errors++; $display("FAIL latency_early: got tick=%b want 0", mon_if.tick_en);
    end
    cyc(1);
    checks++;
    if (mon_if.tick_en !== 1'b1) begin
      errors++; $display("FAIL latency_hit: got tick=%b want 1", mon_if.tick_en);
    end
    cyc(1);
    checks++;
    if (mon_if.tick_en !== 1'b0) begin
      errors++; $display("FAIL latency_width: got tick=%b want 0", mon_if.tick_en);
    end
    cyc(3);
    mon_if.slow_in = 1'b0;
    cyc(8);
    check_status("sq_rise1", 0, 0, 0, 0);
    pulse_period(16);
    check_status("sq_rise2", 16, 1, 0, 0);
    pulse_period(16);
    check_status("sq_rise3", 16, 1, 1, 0);
    checks++;
    if (tick_cnt - t0 !== 3 || last_tick - prev_tick !== 16) begin
      errors++;
      $display("FAIL sq_ticks: got count=%0d spacing=%0d want count=3 spacing=16",
               tick_cnt - t0, last_tick - prev_tick);
    end
  endtask

  task automatic test_period_change();
    pulse_period(20);                     // this rise still closes a 16 interval
    check_status("chg_still16", 16, 1, 1, 0);
    pulse_period(20);
    check_status("chg_first20", 20, 1, 0, 0);
    pulse_period(20);
    check_status("chg_relock20", 20, 1, 1, 0);
  endtask

  task automatic test_lost();
    // last rise acted on 16 cycles ago; timeout fires 64 cycles after it
    cyc(47);
    check_status("lost_before", 20, 1, 1, 0);
    cyc(1);
    check_status("lost_set", 20, 0, 0, 1);
    pulse_period(16);
    check_status("lost_resume1", 20, 0, 0, 0);
    pulse_period(16);
    check_status("lost_resume2", 16, 1, 0, 0);
  endtask

  task automatic test_glitch();
    int t0;
    t0 = tick_cnt;
    mon_if.slow_in = 1'b1;
    cyc(1);
    mon_if.slow_in = 1'b0;
    cyc(10);
    checks++;
    if (tick_cnt - t0 !== 1) begin
      errors++; $display("FAIL glitch_ticks: got %0d want 1", tick_cnt - t0);
    end
    t0 = tick_cnt;
    mon_if.slow_in = 1'b1;
    cyc(40);
    mon_if.slow_in = 1'b0;
    cyc(8);
    checks++;
    if (tick_cnt - t0 !== 1) begin
      errors++; $display("FAIL long_high_ticks: got %0d want 1", tick_cnt - t0);
    end
  endtask

  task automatic test_timeout_edge();
    clr = 1'b1;
    cyc(2);
    clr = 1'b0;
    cyc(2);
    pulse_period(64);
    pulse_period(64);                     // this rise lands on cnt==63
    check_status("edge64_rise2", 64, 1, 0, 0);
    pulse_period(64);
    check_status("edge64_rise3", 64, 1, 1, 0);
    pulse_period(65);                     // rise on the following call comes one cycle too late
    mon_if.slow_in = 1'b1;
    cyc(3);
    check_status("edge65_lost", 64, 0, 0, 1);
    cyc(1);
    check_status("edge65_resume", 64, 0, 0, 0);
    cyc(4);
    mon_if.slow_in = 1'b0;
    cyc(8);
  endtask

  task automatic test_clr_midrun();
    int t0;
    pulse_period(16);
    pulse_period(16);
    pulse_period(16);
    check_status("clr_prelock", 16, 1, 1, 0);
    mon_if.slow_in = 1'b1;
    cyc(3);
    mon_if.slow_in = 1'b0;
    clr = 1'b1;
    #1;
    check_status("clr_async", 0, 0, 0, 0);
    checks++;
    if (mon_if.tick_en !== 1'b0) begin
      errors++; $display("FAIL clr_tick: got %b want 0", mon_if.tick_en);
    end
    cyc(2);
    clr = 1'b0;
    t0 = tick_cnt;
    cyc(10);
    checks++;
    if (tick_cnt - t0 !== 0) begin
      errors++; $display("FAIL clr_no_tick: got %0d ticks want 0", tick_cnt - t0);
    end
    pulse_period(16);
    pulse_period(16);
    check_status("clr_restart", 16, 1, 0, 0);
    checks++;
    if (tick_cnt - t0 !== 2) begin
      errors++; $display("FAIL clr_restart_ticks: got %0d want 2", tick_cnt - t0);
    end
  endtask

  initial begin
    mon_if.slow_in = 1'b0;
    test_reset();
    test_square();
    test_period_change();
    test_lost();
    test_glitch();
    test_timeout_edge();
    test_clr_midrun();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
